// File: rtl/nes_joypad_pkg.sv
`default_nettype none
// ============================================================================
// nes_joypad_pkg : HID keycodes, button indices and hold-FSM states
// Rev 1.0
// ============================================================================
package nes_joypad_pkg;

  localparam logic [7:0] KEY_K     = 8'h0E;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Player-2 read count at which the port reports "exhausted" (reads 1)
  localparam logic [3:0] P2_DONE = 4'd8;

  typedef enum logic {
    ACTIVE    = 1'b0,
    RELEASING = 1'b1
  } hold_state_e;

  function automatic logic [7:0] decode_key(input logic [7:0] code);
    logic [7:0] btn;
    btn = '0;
    case (code)
      KEY_K:     btn[BTN_A]      = 1'b1;
      KEY_J:     btn[BTN_B]      = 1'b1;
      KEY_SPACE: btn[BTN_SELECT] = 1'b1;
      KEY_ENTER: btn[BTN_START]  = 1'b1;
      KEY_W:     btn[BTN_UP]     = 1'b1;
      KEY_S:     btn[BTN_DOWN]   = 1'b1;
      KEY_A:     btn[BTN_LEFT]   = 1'b1;
      KEY_D:     btn[BTN_RIGHT]  = 1'b1;
      default:   btn             = '0;
    endcase
    return btn;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nes_joypad_shift.sv
`default_nettype none
// ============================================================================
// nes_joypad_shift : $4016/$4017 strobe, 8-bit serial shifter, player-2 counter
// Rev 1.0
// ============================================================================
module nes_joypad_shift
  import nes_joypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_ce,
  input  logic       sel,
  input  logic       wr_en,
  input  logic       wr_strobe,
  input  logic       rd_en,
  input  logic [7:0] buttons,
  output logic       joy_d0
);

  logic       strobe_q, strobe_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] p2_cnt_q, p2_cnt_d;

  logic wr_fire;
  logic rd_fire;
  logic load;

  assign wr_fire = cpu_ce & wr_en;
  assign rd_fire = cpu_ce & rd_en;
  // A write that raises the strobe reloads on the same edge and suppresses any shift
  assign load    = strobe_q | (wr_fire & wr_strobe);

  always_comb begin
    strobe_d = strobe_q;
    shift_d  = shift_q;
    p2_cnt_d = p2_cnt_q;
    if (wr_fire) strobe_d = wr_strobe;
    if (load) begin
      shift_d  = buttons;
      p2_cnt_d = '0;
    end else if (rd_fire) begin
      if (!sel) begin
        shift_d = {1'b1, shift_q[7:1]};
      end else if (p2_cnt_q != P2_DONE) begin
        p2_cnt_d = p2_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      shift_q  <= '0;
      // Player 2 leaves reset already exhausted so an unstrobed port reads 1
      p2_cnt_q <= P2_DONE;
    end else begin
      strobe_q <= strobe_d;
      shift_q  <= shift_d;
      p2_cnt_q <= p2_cnt_d;
    end
  end

  assign joy_d0 = sel      ? (p2_cnt_q == P2_DONE)
                : strobe_q ? buttons[BTN_A]
                :            shift_q[0];

endmodule
`default_nettype wire

// File: rtl/nes_joypad_ctrl.sv
`default_nettype none
// ============================================================================
// nes_joypad_ctrl : keyboard keycode -> NES controller with release hold
// Rev 1.0
// ============================================================================
module nes_joypad_ctrl
  import nes_joypad_pkg::*;
#(
  parameter int HOLD_CYCLES = 500000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] keycode,
  input  logic       cpu_ce,
  input  logic       sel,
  input  logic       wr_en,
  input  logic       wr_strobe,
  input  logic       rd_en,
  output logic       joy_d0,
  output logic [7:0] buttons
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  hold_state_e      state_q, state_d;
  logic [7:0]       buttons_q, buttons_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       decode;

  assign decode = decode_key(keycode);

  always_comb begin
    state_d   = state_q;
    buttons_d = buttons_q;
    cnt_d     = cnt_q;
    case (state_q)
      ACTIVE: begin
        if (decode != 8'h00) begin
          buttons_d = decode;
          cnt_d     = HOLD_LOAD;
        end else if (buttons_q != 8'h00) begin
          state_d = RELEASING;
        end
      end
      RELEASING: begin
        if (decode != 8'h00) begin
          buttons_d = decode;
          cnt_d     = HOLD_LOAD;
          state_d   = ACTIVE;
        end else if (cnt_q <= CNT_ONE) begin
          // Edge on which the count reaches zero drops the buttons
          cnt_d     = '0;
          buttons_d = 8'h00;
          state_d   = ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACTIVE;
      buttons_q <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      buttons_q <= buttons_d;
      cnt_q     <= cnt_d;
    end
  end

  assign buttons = buttons_q;

  nes_joypad_shift u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_ce    (cpu_ce),
    .sel       (sel),
    .wr_en     (wr_en),
    .wr_strobe (wr_strobe),
    .rd_en     (rd_en),
    .buttons   (buttons_q),
    .joy_d0    (joy_d0)
  );

endmodule
`default_nettype wire
